pc_redirect_ctrl: RTL and testbench

Holds the fetch PC register and carries each fetched instruction's YAGS prediction alongside the pipeline to EX. Compares that prediction against the resolved branch/jump outcome and drives the 2-bit next-PC select consumed by the IF-stage PC mux. Raises front-end flushes on redirect. Issues a registered YAGS training update and keeps branch/mispredict performance counters.

---
 rtl/if_pkg.sv | 19 +
 rtl/pred_meta_pipe.sv | 44 ++++
 rtl/pc_redirect_ctrl.sv | 100 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared front-end types: next-PC select encoding and per-instruction prediction metadata.
package if_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SEL_SEQ      = 2'b00,
        SEL_NT_T_FIX = 2'b01,
        SEL_JUMP     = 2'b10,
        SEL_T_NT_FIX = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
    } pred_meta_t;

endpackage

// File: rtl/pred_meta_pipe.sv
// ID/EX prediction-metadata slots: stall holds ID and bubbles EX; flush invalidates both.
module pred_meta_pipe
    import if_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pred_i,
    output pred_meta_t      id_o,
    output pred_meta_t      ex_o
);

    pred_meta_t id_q, id_d;
    pred_meta_t ex_q, ex_d;

    always_comb begin
        id_d = id_q;
        ex_d = id_q;
        if (flush_i) begin
            id_d = '{valid: 1'b0, pc: pc_i, pred_taken: pred_i};
            ex_d.valid = 1'b0;
        end else if (stall_i) begin
            ex_d.valid = 1'b0;
        end else begin
            id_d = '{valid: 1'b1, pc: pc_i, pred_taken: pred_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign id_o = id_q;
    assign ex_o = ex_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register, EX-stage prediction resolution, flush/redirect control, YAGS training and perf counters.
module pc_redirect_ctrl
    import if_pkg::*;
#(
    parameter int unsigned size     = 32,
    parameter logic [size-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             pred_taken_IF,
    input  logic [size-1:0]  next_pc_in,
    input  logic             branch_EX,
    input  logic             branch_taken_EX,
    input  logic             jump_EX,
    output logic [size-1:0]  PC_out,
    output logic [size-1:0]  PC_EX,
    output logic [1:0]       PC_adder_mux_select,
    output logic             jump_flag_EX_out,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             yags_update_valid,
    output logic             yags_update_taken,
    output logic [size-1:0]  yags_update_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    pred_meta_t id_meta, ex_meta;
    pc_sel_e    sel;
    logic       redirect, is_branch, is_mispred;

    logic [size-1:0]  pc_q, upd_pc_q;
    logic             upd_valid_q, upd_taken_q;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    pred_meta_pipe u_meta (
        .clk_i   (clk),
        .reset_i (reset),
        .stall_i (stall_in),
        .flush_i (redirect),
        .pc_i    (XLEN'(pc_q)),
        .pred_i  (pred_taken_IF),
        .id_o    (id_meta),
        .ex_o    (ex_meta)
    );

    always_comb begin
        sel              = SEL_SEQ;
        jump_flag_EX_out = 1'b0;
        if (ex_meta.valid) begin
            if (jump_EX) begin
                sel              = SEL_JUMP;
                jump_flag_EX_out = 1'b1;
            end else if (branch_EX && branch_taken_EX && !ex_meta.pred_taken) begin
                sel = SEL_NT_T_FIX;
            end else if (branch_EX && !branch_taken_EX && ex_meta.pred_taken) begin
                sel = SEL_T_NT_FIX;
            end
        end
    end

    assign redirect   = (sel != SEL_SEQ);
    // A jump that also shows branch flags is still a jump: it neither trains nor counts as a branch.
    assign is_branch  = ex_meta.valid && branch_EX && !jump_EX;
    assign is_mispred = (sel == SEL_NT_T_FIX) || (sel == SEL_T_NT_FIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= '0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
        end else begin
            if (redirect || !stall_in) pc_q <= next_pc_in;
            upd_valid_q <= is_branch;
            if (is_branch) begin
                upd_taken_q <= branch_taken_EX;
                upd_pc_q    <= size'(ex_meta.pc);
                br_cnt_q    <= br_cnt_q + CNT_W'(1);
            end
            if (is_mispred) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        end
    end

    assign PC_out              = pc_q;
    assign PC_EX               = size'(ex_meta.pc);
    assign PC_adder_mux_select = sel;
    assign flush_IF_ID         = redirect;
    assign flush_ID_EX         = redirect;
    assign yags_update_valid   = upd_valid_q;
    assign yags_update_taken   = upd_taken_q;
    assign yags_update_pc      = upd_pc_q;
    assign branch_count        = br_cnt_q;
    assign mispredict_count    = mis_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: sequential fetch, mispredict fixes, jumps, stalls, reset.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall_in, pred_taken_IF;
    logic [31:0] next_pc_in;
    logic        branch_EX, branch_taken_EX, jump_EX;
    logic [31:0] PC_out, PC_EX, yags_update_pc;
    logic [1:0]  PC_adder_mux_select;
    logic        jump_flag_EX_out, flush_IF_ID, flush_ID_EX;
    logic        yags_update_valid, yags_update_taken;
    logic [31:0] branch_count, mispredict_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.size(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .pred_taken_IF(pred_taken_IF),
        .next_pc_in(next_pc_in), .branch_EX(branch_EX), .branch_taken_EX(branch_taken_EX),
        .jump_EX(jump_EX), .PC_out(PC_out), .PC_EX(PC_EX),
        .PC_adder_mux_select(PC_adder_mux_select), .jump_flag_EX_out(jump_flag_EX_out),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .yags_update_valid(yags_update_valid), .yags_update_taken(yags_update_taken),
        .yags_update_pc(yags_update_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] nxt);
        next_pc_in = nxt;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; pred_taken_IF = 1'b0; next_pc_in = 32'h4;
        branch_EX = 1'b0; branch_taken_EX = 1'b0; jump_EX = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (PC_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PC_out, 32'h0); end
        checks++; if (PC_adder_mux_select !== 2'b00 || flush_IF_ID !== 1'b0 || flush_ID_EX !== 1'b0)
            begin errors++; $display("FAIL reset_sel got=%b/%b%b exp=00/00", PC_adder_mux_select, flush_IF_ID, flush_ID_EX); end
        checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || yags_update_valid !== 1'b0)
            begin errors++; $display("FAIL reset_cnt got=%0d/%0d/%b exp=0/0/0", branch_count, mispredict_count, yags_update_valid); end
    endtask

    task automatic test_sequential();
        step(32'h4);
        checks++; if (PC_out !== 32'h4) begin errors++; $display("FAIL seq_pc4 got=%h exp=%h", PC_out, 32'h4); end
        step(32'h8);
        checks++; if (PC_out !== 32'h8) begin errors++; $display("FAIL seq_pc8 got=%h exp=%h", PC_out, 32'h8); end
        checks++; if (PC_EX !== 32'h0 || PC_adder_mux_select !== 2'b00 || flush_IF_ID !== 1'b0)
            begin errors++; $display("FAIL seq_ex got=%h/%b/%b exp=0/00/0", PC_EX, PC_adder_mux_select, flush_IF_ID); end
        step(32'hC);
        step(32'h10);
    endtask

    task automatic test_branch_nt_t();
        pred_taken_IF = 1'b0;
        step(32'h14);
        step(32'h18);
        branch_EX = 1'b1; branch_taken_EX = 1'b1; next_pc_in = 32'h40;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b01 || flush_IF_ID !== 1'b1 || flush_ID_EX !== 1'b1 || PC_EX !== 32'h10)
            begin errors++; $display("FAIL ntt_sel got=%b/%b%b/%h exp=01/11/10", PC_adder_mux_select, flush_IF_ID, flush_ID_EX, PC_EX); end
        tick();
        checks++; if (PC_out !== 32'h40) begin errors++; $display("FAIL ntt_pc got=%h exp=%h", PC_out, 32'h40); end
        checks++; if (yags_update_valid !== 1'b1 || yags_update_taken !== 1'b1 || yags_update_pc !== 32'h10)
            begin errors++; $display("FAIL ntt_upd got=%b/%b/%h exp=1/1/10", yags_update_valid, yags_update_taken, yags_update_pc); end
        checks++; if (mispredict_count !== 32'd1 || branch_count !== 32'd1)
            begin errors++; $display("FAIL ntt_cnt got=%0d/%0d exp=1/1", mispredict_count, branch_count); end
        // flushed EX must ignore branch inputs still asserted
        checks++; if (PC_adder_mux_select !== 2'b00 || flush_IF_ID !== 1'b0)
            begin errors++; $display("FAIL ntt_flushed got=%b/%b exp=00/0", PC_adder_mux_select, flush_IF_ID); end
        branch_EX = 1'b0; branch_taken_EX = 1'b0;
        step(32'h44);
        checks++; if (yags_update_valid !== 1'b0 || branch_count !== 32'd1)
            begin errors++; $display("FAIL ntt_pulse got=%b/%0d exp=0/1", yags_update_valid, branch_count); end
        step(32'h20);
    endtask

    task automatic test_branch_t_nt();
        pred_taken_IF = 1'b1;
        step(32'h24);
        pred_taken_IF = 1'b0;
        step(32'h28);
        branch_EX = 1'b1; branch_taken_EX = 1'b0; next_pc_in = 32'h24;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b11 || flush_ID_EX !== 1'b1 || PC_EX !== 32'h20)
            begin errors++; $display("FAIL tnt_sel got=%b/%b/%h exp=11/1/20", PC_adder_mux_select, flush_ID_EX, PC_EX); end
        tick();
        branch_EX = 1'b0;
        checks++; if (PC_out !== 32'h24 || yags_update_valid !== 1'b1 || yags_update_taken !== 1'b0 || yags_update_pc !== 32'h20)
            begin errors++; $display("FAIL tnt_upd got=%h/%b/%b/%h exp=24/1/0/20", PC_out, yags_update_valid, yags_update_taken, yags_update_pc); end
        checks++; if (branch_count !== 32'd2 || mispredict_count !== 32'd2)
            begin errors++; $display("FAIL tnt_cnt got=%0d/%0d exp=2/2", branch_count, mispredict_count); end
    endtask

    task automatic test_jump();
        pred_taken_IF = 1'b1;
        step(32'h28);
        pred_taken_IF = 1'b0;
        step(32'h2C);
        jump_EX = 1'b1; branch_EX = 1'b1; branch_taken_EX = 1'b1; next_pc_in = 32'h80;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b10 || jump_flag_EX_out !== 1'b1 || flush_IF_ID !== 1'b1)
            begin errors++; $display("FAIL jmp_sel got=%b/%b/%b exp=10/1/1", PC_adder_mux_select, jump_flag_EX_out, flush_IF_ID); end
        tick();
        jump_EX = 1'b0; branch_EX = 1'b0; branch_taken_EX = 1'b0;
        checks++; if (PC_out !== 32'h80 || yags_update_valid !== 1'b0)
            begin errors++; $display("FAIL jmp_pc got=%h/%b exp=80/0", PC_out, yags_update_valid); end
        checks++; if (branch_count !== 32'd2 || mispredict_count !== 32'd2)
            begin errors++; $display("FAIL jmp_cnt got=%0d/%0d exp=2/2", branch_count, mispredict_count); end
    endtask

    task automatic test_stall();
        step(32'h84);
        step(32'h88);
        stall_in = 1'b1;
        step(32'h8C);
        checks++; if (PC_out !== 32'h88) begin errors++; $display("FAIL stall_hold1 got=%h exp=%h", PC_out, 32'h88); end
        branch_EX = 1'b1; branch_taken_EX = 1'b1;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b00 || flush_IF_ID !== 1'b0)
            begin errors++; $display("FAIL stall_bubble got=%b/%b exp=00/0", PC_adder_mux_select, flush_IF_ID); end
        tick();
        checks++; if (PC_out !== 32'h88 || branch_count !== 32'd2 || yags_update_valid !== 1'b0)
            begin errors++; $display("FAIL stall_hold2 got=%h/%0d/%b exp=88/2/0", PC_out, branch_count, yags_update_valid); end
        branch_EX = 1'b0; branch_taken_EX = 1'b0; stall_in = 1'b0;
        step(32'h8C);
        checks++; if (PC_out !== 32'h8C || PC_EX !== 32'h84)
            begin errors++; $display("FAIL stall_resume got=%h/%h exp=8c/84", PC_out, PC_EX); end
        stall_in = 1'b1; branch_EX = 1'b1; branch_taken_EX = 1'b1; next_pc_in = 32'hC0;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b01) begin errors++; $display("FAIL stall_redir_sel got=%b exp=01", PC_adder_mux_select); end
        tick();
        stall_in = 1'b0; branch_EX = 1'b0; branch_taken_EX = 1'b0;
        checks++; if (PC_out !== 32'hC0 || mispredict_count !== 32'd3 || branch_count !== 32'd3)
            begin errors++; $display("FAIL stall_redir got=%h/%0d/%0d exp=c0/3/3", PC_out, mispredict_count, branch_count); end
    endtask

    task automatic test_reset_during_redirect();
        step(32'hC4);
        step(32'hC8);
        branch_EX = 1'b1; branch_taken_EX = 1'b1; next_pc_in = 32'hF0;
        #1;
        checks++; if (PC_adder_mux_select !== 2'b01) begin errors++; $display("FAIL rstr_sel got=%b exp=01", PC_adder_mux_select); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (PC_out !== 32'h0 || PC_EX !== 32'h0 || PC_adder_mux_select !== 2'b00 || flush_IF_ID !== 1'b0)
            begin errors++; $display("FAIL rstr_pc got=%h/%h/%b/%b exp=0/0/00/0", PC_out, PC_EX, PC_adder_mux_select, flush_IF_ID); end
        checks++; if (yags_update_valid !== 1'b0 || yags_update_taken !== 1'b0 || yags_update_pc !== 32'h0 ||
                      branch_count !== 32'd0 || mispredict_count !== 32'd0)
            begin errors++; $display("FAIL rstr_state got=%b/%b/%h/%0d/%0d exp=0/0/0/0/0", yags_update_valid,
                                     yags_update_taken, yags_update_pc, branch_count, mispredict_count); end
        branch_EX = 1'b0; branch_taken_EX = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_nt_t();
        test_branch_t_nt();
        test_jump();
        test_stall();
        test_reset_during_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
